// File: rtl/instr_mem_arbiter_if.sv
// Bus bundle for the instruction memory arbiter: loader stream, fetch
// port, memory port and boot status. slave = arbiter, master = environment.
interface instr_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // loader stream
    logic              load_start_i;
    logic              load_valid_i;
    logic [DATA_W-1:0] load_data_i;
    logic              load_last_i;
    logic              load_ready_o;
    // fetch port
    logic              fetch_req_i;
    logic [31:0]       fetch_pc_i;
    logic [DATA_W-1:0] fetch_instr_o;
    logic              fetch_valid_o;
    logic              fetch_stall_o;
    // memory port
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    // boot status
    logic              cpu_run_o;
    logic [ADDR_W:0]   load_count_o;
    logic              load_err_o;

    modport slave (
        input  load_start_i, load_valid_i, load_data_i, load_last_i,
        input  fetch_req_i, fetch_pc_i, mem_rdata_i,
        output load_ready_o, fetch_instr_o, fetch_valid_o, fetch_stall_o,
        output mem_addr_o, mem_we_o, mem_wdata_o,
        output cpu_run_o, load_count_o, load_err_o
    );

    modport master (
        output load_start_i, load_valid_i, load_data_i, load_last_i,
        output fetch_req_i, fetch_pc_i, mem_rdata_i,
        input  load_ready_o, fetch_instr_o, fetch_valid_o, fetch_stall_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o,
        input  cpu_run_o, load_count_o, load_err_o
    );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Single-port instruction memory arbiter: boot loader writes the program,
// then the core is released and fetches get a registered one-cycle read.
// Optional macro INSTR_MEM_ZERO_FILL_EN adds a FILL state that zeroes the
// words above the loaded program before the core is released.
module instr_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    instr_mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef INSTR_MEM_ZERO_FILL_EN
        S_FILL,
`endif
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_TOP = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              run_q, run_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              fvalid_q, fvalid_d;

    logic              pc_ok;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // A PC is serviceable only when word aligned and inside the memory.
    assign pc_ok = (bus.fetch_pc_i[1:0] == 2'b00) &&
                   (bus.fetch_pc_i[31:ADDR_W+2] == '0);

    // Next-state: boot sequencing, load pointer/count and fetch response.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        instr_d  = instr_q;
        fvalid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.load_start_i) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                if (bus.load_start_i) begin
                    ptr_d   = '0;
                    count_d = '0;
                end else if (bus.load_valid_i) begin
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (bus.load_last_i) begin
`ifdef INSTR_MEM_ZERO_FILL_EN
                        // Program reaching the top address leaves nothing to fill.
                        state_d = (ptr_q == PTR_TOP) ? S_RUN : S_FILL;
`else
                        state_d = S_RUN;
`endif
                    end else if (ptr_q == PTR_TOP) begin
                        // Program longer than memory: the top word is kept, load aborts.
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`ifdef INSTR_MEM_ZERO_FILL_EN
            S_FILL: begin
                if (bus.load_start_i) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == PTR_TOP) state_d = S_RUN;
                end
            end
`endif
            S_RUN: begin
                // The read issued this cycle completes even if a reload starts now.
                if (bus.fetch_req_i) begin
                    fvalid_d = 1'b1;
                    instr_d  = pc_ok ? bus.mem_rdata_i : '0;
                end
                if (bus.load_start_i) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            S_ERR: begin
                if (bus.load_start_i) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state.
    always_comb begin
        ready_d = (state_d == S_LOAD);
        run_d   = (state_d == S_RUN);
    end

    // Memory port mux: loader (or zero fill) owns it until RUN, then the PC does.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_LOAD: begin
                mem_addr  = ptr_q;
                mem_we    = bus.load_valid_i;
                mem_wdata = bus.load_data_i;
            end
`ifdef INSTR_MEM_ZERO_FILL_EN
            S_FILL: begin
                mem_addr = ptr_q;
                mem_we   = 1'b1;
            end
`endif
            S_RUN:   mem_addr = bus.fetch_pc_i[ADDR_W+1:2];
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            run_q    <= 1'b0;
            instr_q  <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            run_q    <= run_d;
            instr_q  <= instr_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign bus.load_ready_o  = ready_q;
    assign bus.cpu_run_o     = run_q;
    assign bus.fetch_stall_o = ~run_q;
    assign bus.fetch_valid_o = fvalid_q;
    assign bus.fetch_instr_o = instr_q;
    assign bus.load_count_o  = count_q;
    assign bus.load_err_o    = err_q;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_we_o      = mem_we;
    assign bus.mem_wdata_o   = mem_wdata;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: fetch vector table, hand-written boot/error/
// reload sequences and randomized loads+fetches against a memory-image model.
module tb_instr_mem_arbiter;

    localparam int DEPTH = 1024;

    logic clk;
    logic rst_n;
    logic mem_clr;

    instr_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus();

    instr_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array behind the arbiter; write counter tracks every write strobe.
    logic [31:0] mem [0:DEPTH-1];
    int          wr_cnt;
    assign bus.mem_rdata_i = mem[bus.mem_addr_o];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= 32'h0;
            wr_cnt <= 0;
        end else if (bus.mem_we_o) begin
            mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference: intended memory image and the last fetch result.
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] prog    [0:DEPTH-1];
    logic [31:0] exp_hold;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        exp_valid;
        logic [31:0] exp_instr;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected fetch word: aligned byte address inside the array, else NOP.
    function automatic logic [31:0] model_fetch(input logic [31:0] pc);
        if ((pc % 4) != 0 || pc >= 4 * DEPTH) return 32'h0;
        return ref_mem[pc / 4];
    endfunction

    task automatic do_load(input int n, input bit with_last, input bit start, input int gap);
        int i = 0;
        int guard = 0;
        bit acc;
        if (start) begin
            bus.load_start_i = 1'b1;
            step();
            bus.load_start_i = 1'b0;
        end
        while (i < n && guard < 4 * n + 100) begin
            guard++;
            if (gap > 0 && $urandom_range(99) < gap) begin
                bus.load_valid_i = 1'b0;
                bus.load_last_i  = 1'b0;
            end else begin
                bus.load_valid_i = 1'b1;
                bus.load_data_i  = prog[i];
                bus.load_last_i  = with_last && (i == n - 1);
            end
            acc = bus.load_valid_i && bus.load_ready_o;
            if (acc) ref_mem[i] = prog[i];
            step();
            if (acc) i++;
        end
        bus.load_valid_i = 1'b0;
        bus.load_last_i  = 1'b0;
        chk("load_beats_accepted", i, n);
`ifdef INSTR_MEM_ZERO_FILL_EN
        if (with_last) for (int j = n; j < DEPTH; j++) ref_mem[j] = 32'h0;
`endif
    endtask

    task automatic wait_run(input int bound);
        int c = 0;
        while (!bus.cpu_run_o && c < bound) begin
            step();
            c++;
        end
        chk("run_within_bound", bus.cpu_run_o, 1);
    endtask

    task automatic fetch(input string nm, input logic [31:0] pc, input bit req);
        bus.fetch_pc_i  = pc;
        bus.fetch_req_i = req;
        step();
        bus.fetch_req_i = 1'b0;
        if (req) exp_hold = model_fetch(pc);
        chk({nm, "_valid"}, bus.fetch_valid_o, req);
        chk({nm, "_instr"}, bus.fetch_instr_o, exp_hold);
    endtask

    initial begin
        vt[0] = '{32'h0000_0000, 1'b1, 1'b1, 32'h2008_0005};
        vt[1] = '{32'h0000_0004, 1'b1, 1'b1, 32'h2009_0003};
        vt[2] = '{32'h0000_0008, 1'b1, 1'b1, 32'h0109_5020};
        vt[3] = '{32'h0000_0004, 1'b0, 1'b0, 32'h0109_5020};
        vt[4] = '{32'h0000_000C, 1'b1, 1'b1, 32'h0000_0000};
        vt[5] = '{32'h0000_0006, 1'b1, 1'b1, 32'h0000_0000};
        vt[6] = '{32'h0000_1000, 1'b1, 1'b1, 32'h0000_0000};
        vt[7] = '{32'h0000_0002, 1'b1, 1'b1, 32'h0000_0000};

        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
        exp_hold         = 32'h0;
        bus.load_start_i = 1'b0;
        bus.load_valid_i = 1'b0;
        bus.load_data_i  = 32'h0;
        bus.load_last_i  = 1'b0;
        bus.fetch_req_i  = 1'b0;
        bus.fetch_pc_i   = 32'h0;
        mem_clr = 1'b1;
        rst_n   = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_run",   bus.cpu_run_o, 0);
        chk("rst_stall",     bus.fetch_stall_o, 1);
        chk("rst_count",     bus.load_count_o, 0);
        chk("rst_ready",     bus.load_ready_o, 0);
        chk("rst_err",       bus.load_err_o, 0);
        chk("rst_valid",     bus.fetch_valid_o, 0);
        chk("rst_we",        bus.mem_we_o, 0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        bus.fetch_req_i = 1'b1;
        step();
        bus.fetch_req_i = 1'b0;
        chk("idle_fetch_ignored", bus.fetch_valid_o, 0);
        chk("idle_stall", bus.fetch_stall_o, 1);

        // Boot load of a 4-word program.
        prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020; prog[3] = 32'h0000_0000;
        begin
            int w0 = wr_cnt;
            do_load(4, 1'b1, 1'b1, 0);
`ifdef INSTR_MEM_ZERO_FILL_EN
            wait_run(1100);
            chk("boot_write_count", wr_cnt - w0, DEPTH);
`else
            chk("boot_run_next_cycle", bus.cpu_run_o, 1);
            chk("boot_write_count", wr_cnt - w0, 4);
`endif
        end
        chk("boot_count", bus.load_count_o, 4);
        chk("boot_stall", bus.fetch_stall_o, 0);
        for (int k = 0; k < 4; k++) chk("boot_mem_word", mem[k], prog[k]);

        // Fetch vector table.
        for (int k = 0; k < 8; k++) begin
            bus.fetch_pc_i  = vt[k].pc;
            bus.fetch_req_i = vt[k].req;
            step();
            bus.fetch_req_i = 1'b0;
            chk("vec_valid", bus.fetch_valid_o, vt[k].exp_valid);
            chk("vec_instr", bus.fetch_instr_o, vt[k].exp_instr);
        end
        exp_hold = 32'h0;

        // Overlong program: 1024 beats and no last flag.
        for (int k = 0; k < DEPTH; k++) prog[k] = 32'hA500_0000 | k;
        do_load(DEPTH, 1'b0, 1'b1, 0);
        chk("err_flag",    bus.load_err_o, 1);
        chk("err_run",     bus.cpu_run_o, 0);
        chk("err_ready",   bus.load_ready_o, 0);
        chk("err_stall",   bus.fetch_stall_o, 1);
        chk("err_count",   bus.load_count_o, DEPTH);
        chk("err_top_word", mem[DEPTH-1], 32'hA500_03FF);
        bus.fetch_req_i = 1'b1;
        step();
        bus.fetch_req_i = 1'b0;
        chk("err_fetch_ignored", bus.fetch_valid_o, 0);
        bus.load_start_i = 1'b1;
        step();
        bus.load_start_i = 1'b0;
        chk("err_cleared", bus.load_err_o, 0);
        chk("err_restart_ready", bus.load_ready_o, 1);
        chk("err_restart_count", bus.load_count_o, 0);
        prog[0] = 32'h2008_0005; prog[1] = 32'h2009_0003;
        prog[2] = 32'h0109_5020; prog[3] = 32'h0000_0000;
        do_load(4, 1'b1, 1'b0, 0);
        wait_run(1100);

        // Reload from RUN with a fetch in flight on the same edge.
        bus.fetch_pc_i   = 32'h8;
        bus.fetch_req_i  = 1'b1;
        bus.load_start_i = 1'b1;
        step();
        bus.fetch_req_i  = 1'b0;
        bus.load_start_i = 1'b0;
        chk("reload_inflight_valid", bus.fetch_valid_o, 1);
        chk("reload_inflight_instr", bus.fetch_instr_o, 32'h0109_5020);
        chk("reload_run_drop", bus.cpu_run_o, 0);
        chk("reload_ready", bus.load_ready_o, 1);
        prog[0] = 32'h1111_1111; prog[1] = 32'h2222_2222;
        do_load(2, 1'b1, 1'b0, 0);
`ifdef INSTR_MEM_ZERO_FILL_EN
        begin
            int fc = 0;
            while (!bus.cpu_run_o && fc < 2000) begin
                chk("fill_we", bus.mem_we_o, 1);
                step();
                fc++;
            end
            chk("fill_cycles", fc, DEPTH - 2);
        end
`else
        chk("reload_run_next_cycle", bus.cpu_run_o, 1);
`endif
        chk("reload_count", bus.load_count_o, 2);
        fetch("reload_pc4", 32'h4, 1'b1);
        fetch("reload_pc8", 32'h8, 1'b1);
        fetch("reload_pc10", 32'h10, 1'b1);

        // Reset in the middle of a load.
        for (int k = 0; k < 3; k++) prog[k] = 32'h3300_0000 | k;
        do_load(3, 1'b0, 1'b1, 0);
        rst_n = 1'b0;
        #2;
        chk("midrst_ready", bus.load_ready_o, 0);
        chk("midrst_count", bus.load_count_o, 0);
        chk("midrst_stall", bus.fetch_stall_o, 1);
        step();
        rst_n = 1'b1;
        step();

        // Randomized loads (some restarted mid-stream) and fetches.
        for (int it = 0; it < 15; it++) begin
            int len = $urandom_range(40, 1);
            int gap = $urandom_range(50, 0);
            if ($urandom_range(3) == 0) begin
                int ab = $urandom_range(20, 1);
                for (int k = 0; k < ab; k++) prog[k] = $urandom;
                do_load(ab, 1'b0, 1'b1, gap);
            end
            for (int k = 0; k < len; k++) prog[k] = $urandom;
            do_load(len, 1'b1, 1'b1, gap);
            wait_run(1100);
            chk("rnd_count", bus.load_count_o, len);
            begin
                int errs = 0;
                for (int k = 0; k < DEPTH; k++) if (mem[k] !== ref_mem[k]) errs++;
                chk("rnd_mem_image", errs, 0);
            end
            for (int f = 0; f < 25; f++) begin
                int r = $urandom_range(9);
                logic [31:0] pc;
                bit req = 1'b1;
                if (r < 6)       pc = $urandom_range(DEPTH - 1) * 4;
                else if (r == 6) pc = ($urandom_range(DEPTH - 1) * 4) | $urandom_range(3, 1);
                else if (r == 7) pc = $urandom | 32'h0000_1000;
                else begin
                    pc  = $urandom;
                    req = (f == 0);
                end
                fetch("rnd_fetch", pc, req);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
